// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and the state encoding of the command master FSM.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4
    } master_state_e;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns one valid/ready command into one
// AXI read or write and reports completion with a one-cycle response pulse.
module axi_lite_cmd_master
    import axi_lite_pkg::*;
#(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 14
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,

    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,

    output logic                            rsp_valid,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,

    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] WORD_MASK = {{(C_M_AXI_ADDR_WIDTH-2){1'b1}}, 2'b00};

    master_state_e                   state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                            awvalid_q, awvalid_d;
    logic                            wvalid_q, wvalid_d;
    logic                            arvalid_q, arvalid_d;
    logic                            rsp_valid_q, rsp_valid_d;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]                      rsp_resp_q, rsp_resp_d;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // Ready is gated by the reset pin so it reads 0 for the whole reset interval.
    assign cmd_ready = (state_q == ST_IDLE) && M_AXI_ARESETN;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d  = cmd_addr & WORD_MASK;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = ST_WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = ST_RD_ADDR;
                    end
                end
            end
            ST_WR: begin
                // AW and W retire independently; leave only once both are done.
                if (M_AXI_AWREADY) awvalid_d = 1'b0;
                if (M_AXI_WREADY)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (M_AXI_BVALID) begin
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = M_AXI_BRESP;
                    rsp_rdata_d = '0;
                    state_d     = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rsp_valid_d = 1'b1;
                    rsp_resp_d  = M_AXI_RRESP;
                    rsp_rdata_d = M_AXI_RDATA;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = (state_q == ST_WR_RESP);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = (state_q == ST_RD_DATA);

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

endmodule

// File: doc/axi_lite_cmd_master.md
AXI_LITE_CMD_MASTER -- requirements
Module: axi_lite_cmd_master

Interface
REQ-001 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32, AXI data width (only 32 supported).
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 14, AXI address width.
REQ-003 SHALL have port M_AXI_ACLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port M_AXI_ARESETN  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port cmd_valid  input  1  command request.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when both valid and ready are high.
REQ-007 SHALL have port cmd_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have port cmd_addr  input  C_M_AXI_ADDR_WIDTH  byte address.
REQ-009 SHALL have port cmd_wdata  input  32  write data.
REQ-010 SHALL have port cmd_wstrb  input  4  write byte enables.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  32  read data, 0 for writes.
REQ-013 SHALL have port rsp_resp  output  2  captured BRESP/RRESP.
REQ-014 SHALL have ports M_AXI_AWADDR out ADDR_W, M_AXI_AWPROT out 3, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1: write-address channel.
REQ-015 SHALL have ports M_AXI_WDATA out 32, M_AXI_WSTRB out 4, M_AXI_WVALID out 1, M_AXI_WREADY in 1: write-data channel.
REQ-016 SHALL have ports M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1: write-response channel.
REQ-017 SHALL have ports M_AXI_ARADDR out ADDR_W, M_AXI_ARPROT out 3, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1: read-address channel.
REQ-018 SHALL have ports M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1: read-data channel.

Function
REQ-019 SHALL implement FSM IDLE -> WR (cmd_write=1) or RD_ADDR (cmd_write=0) on acceptance; WR -> WR_RESP when both AW and W done; WR_RESP -> IDLE on B handshake; RD_ADDR -> RD_DATA on AR handshake; RD_DATA -> IDLE on R handshake.
REQ-020 SHALL drive cmd_ready high only in IDLE; one outstanding transaction, no pipelining.
REQ-021 SHALL register cmd_addr (bits [1:0] forced 00), cmd_wdata, cmd_wstrb on acceptance; AxADDR/WDATA/WSTRB stable while VALID high.
REQ-022 SHALL assert AWVALID and WVALID together the cycle after acceptance; each drops independently the cycle after its own READY handshake; neither waits on the other's READY.
REQ-023 SHALL assert BREADY only in WR_RESP (after both AW and W done); BVALID earlier is ignored.
REQ-024 SHALL assert ARVALID the cycle after read acceptance, hold until ARREADY; RREADY only in RD_DATA.
REQ-025 SHALL pulse rsp_valid one cycle after the B or R handshake, with rsp_resp and rsp_rdata captured at the handshake; FSM is IDLE (cmd_ready=1) in that cycle, so back-to-back commands are accepted.
REQ-026 SHALL tie AWPROT and ARPROT to 3'b000; wstrb=0 still issues a full write; SLVERR/DECERR is reported, not retried.
REQ-027 SHALL impose no timeout; a stalled slave holds the FSM indefinitely.

Reset
REQ-028 SHALL on ARESETN low immediately force IDLE, all VALID/READY outputs 0, cmd_ready 0 while reset asserted then 1, rsp_valid 0, rsp_rdata 0, rsp_resp 0, address/data registers 0; reset mid-transaction abandons it with no rsp pulse.

Structure
REQ-029 SHALL place AXI response codes (OKAY 2'b00, EXOKAY 2'b01, SLVERR 2'b10, DECERR 2'b11) and the FSM state enum in shared package axi_lite_pkg.
REQ-030 SHALL be a single module with no sub-modules.

Verification
REQ-031 Write addr 0x0010, data 0xDEADBEEF, wstrb 0xF, zero-wait slave -> one AW/W beat with AWADDR 0x0010, rsp_valid pulse with rsp_resp 00.
REQ-032 Read addr 0x2004, slave returns 0x00FF00FF after 4-cycle ARREADY delay -> ARVALID held 4 cycles, rsp_rdata 0x00FF00FF.
REQ-033 Slave asserts WREADY 3 cycles before AWREADY -> WVALID drops first, BREADY only after both done, single rsp.
REQ-034 Slave answers BRESP 2'b10 -> rsp_resp 10, next command accepted in the rsp_valid cycle.
REQ-035 ARESETN low while RD_DATA waiting -> ARVALID/RREADY 0 immediately, no rsp_valid, cmd_ready 1 after release.
REQ-036 cmd_addr 0x0013 write -> AWADDR 0x0010.
